// File: rtl/alu_op_sequencer.sv
// ============================================================================
// alu_op_sequencer : one-at-a-time register-read / ALU / writeback sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
  parameter int RF_RD_LAT = 1,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [3:0]        rf_ra_addr,
  output logic [3:0]        rf_rb_addr,
  input  logic [DATA_W-1:0] rf_ra_data,
  input  logic [DATA_W-1:0] rf_rb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [7:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [4:0]        alu_flags,
  output logic              rf_we,
  output logic [3:0]        rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [4:0]        psr,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [15:0]       instr_q;
  logic [3:0]        ra_q, rb_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, rf_wd_q;
  logic [7:0]        opc_q;
  logic [4:0]        flags_q, psr_q;
  logic              rf_we_q, done_q;

  logic [3:0]        op, ext, code;
  logic              is_imm, flag_wr, no_wb, accept, read_last;
  logic [DATA_W-1:0] imm;

  assign op      = instr_q[15:12];
  assign ext     = instr_q[7:4];
  assign is_imm  = !(op inside {4'b0000, 4'b0100, 4'b1000});
  // ADDUI zero-extends its immediate; every other immediate op sign-extends.
  assign imm     = (op == 4'b0110) ? {{(DATA_W-8){1'b0}}, instr_q[7:0]}
                                   : {{(DATA_W-8){instr_q[7]}}, instr_q[7:0]};
  assign code    = is_imm ? op : ext;
  assign flag_wr = code inside {4'b0101, 4'b0111, 4'b1001, 4'b1011};
  assign no_wb   = (code == 4'b1011) || (instr_q == 16'h0000);

  assign accept    = instr_valid && (state_q == S_IDLE);
  assign read_last = (cnt_q == 2'(RF_RD_LAT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 2'd0;
        if (accept) state_d = S_READ;
      end
      S_READ: begin
        if (read_last) state_d = S_EXEC;
        else           cnt_d   = cnt_q + 2'd1;
      end
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= 16'h0000;
      ra_q    <= 4'd0;
      rb_q    <= 4'd0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      opc_q   <= 8'h00;
      rf_wd_q <= '0;
      flags_q <= 5'd0;
      psr_q   <= 5'd0;
      rf_we_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rf_we_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            instr_q <= instr;
            ra_q    <= instr[11:8];
            rb_q    <= instr[3:0];
          end
        end
        S_READ: begin
          // ALU inputs only move here, so the ALU sees stable operands otherwise.
          if (read_last) begin
            alu_a_q <= rf_ra_data;
            alu_b_q <= is_imm ? imm : rf_rb_data;
            opc_q   <= is_imm ? {op, 4'b0000} : {op, ext};
          end
        end
        S_EXEC: begin
          rf_wd_q <= alu_c;
          flags_q <= alu_flags;
          rf_we_q <= !no_wb;
          done_q  <= 1'b1;
        end
        S_WB: begin
          if (flag_wr) psr_q <= flags_q;
        end
        default: ;
      endcase
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign rf_ra_addr  = ra_q;
  assign rf_rb_addr  = rb_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_opcode  = opc_q;
  assign rf_we       = rf_we_q;
  assign rf_wa       = instr_q[11:8];
  assign rf_wd       = rf_wd_q;
  assign psr         = psr_q;
  assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// tb_alu_op_sequencer : directed self-checking bench, RF_RD_LAT=1 and =2 units
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rf [16];

  // Unit 1: RF_RD_LAT = 1, combinational register-file read
  logic        valid1, ready1, we1, done1;
  logic [15:0] instr1, ra_data1, rb_data1, a1, b1, c1, wd1;
  logic [3:0]  ra1, rb1, wa1;
  logic [7:0]  opc1;
  logic [4:0]  flags1, psr1;

  // Unit 2: RF_RD_LAT = 2, one registered stage in the read path
  logic        valid2, ready2, we2, done2;
  logic [15:0] instr2, ra_data2, rb_data2, a2, b2, c2, wd2;
  logic [3:0]  ra2, rb2, wa2;
  logic [7:0]  opc2;
  logic [4:0]  flags2, psr2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Reference ALU: returns {flags{N,Z,F,L,C}, result}
  function automatic logic [20:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [7:0] opc);
    logic [16:0] s;
    logic [15:0] c;
    logic        cy;
    cy = 1'b0;
    case (opc)
      8'h01:        c = a & b;
      8'h0B, 8'hB0: c = a - b;
      default: begin
        s  = {1'b0, a} + {1'b0, b};
        c  = s[15:0];
        cy = s[16];
      end
    endcase
    return {c[15], (c == 16'h0000), 1'b0, (a < b), cy, c};
  endfunction

  assign ra_data1         = rf[ra1];
  assign rb_data1         = rf[rb1];
  assign {flags1, c1}     = alu_f(a1, b1, opc1);
  assign {flags2, c2}     = alu_f(a2, b2, opc2);

  always @(posedge clk) begin
    ra_data2 <= rf[ra2];
    rb_data2 <= rf[rb2];
  end

  alu_op_sequencer #(.RF_RD_LAT(1), .DATA_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .instr_valid(valid1), .instr_ready(ready1), .instr(instr1),
    .rf_ra_addr(ra1), .rf_rb_addr(rb1), .rf_ra_data(ra_data1), .rf_rb_data(rb_data1),
    .alu_a(a1), .alu_b(b1), .alu_opcode(opc1), .alu_c(c1), .alu_flags(flags1),
    .rf_we(we1), .rf_wa(wa1), .rf_wd(wd1), .psr(psr1), .done(done1)
  );

  alu_op_sequencer #(.RF_RD_LAT(2), .DATA_W(16)) u_dut2 (
    .clk(clk), .reset(reset), .instr_valid(valid2), .instr_ready(ready2), .instr(instr2),
    .rf_ra_addr(ra2), .rf_rb_addr(rb2), .rf_ra_data(ra_data2), .rf_rb_data(rb_data2),
    .alu_a(a2), .alu_b(b2), .alu_opcode(opc2), .alu_c(c2), .alu_flags(flags2),
    .rf_we(we2), .rf_wa(wa2), .rf_wd(wd2), .psr(psr2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one instruction on unit 1 and check it through retirement.
  task automatic run1(input string tag, input logic [15:0] ins, input logic exp_we,
                      input logic [15:0] exp_wd, input logic [15:0] exp_b,
                      input logic [7:0] exp_opc, input logic [4:0] exp_psr);
    int cyc;
    chk({tag, "_ready"}, 32'(ready1), 32'd1);
    instr1 = ins;
    valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    cyc = 1;
    while (done1 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'd3);
    chk({tag, "_we"},  32'(we1), 32'(exp_we));
    if (exp_we) chk({tag, "_wa"}, 32'(wa1), 32'(ins[11:8]));
    chk({tag, "_wd"},  32'(wd1), 32'(exp_wd));
    chk({tag, "_b"},   32'(b1),  32'(exp_b));
    chk({tag, "_opc"}, 32'(opc1), 32'(exp_opc));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done1), 32'd0);
    chk({tag, "_psr"}, 32'(psr1), 32'(exp_psr));
  endtask

  initial begin
    int bad, nacc, last_acc, dbl;
    logic prev_done;
    for (int i = 0; i < 16; i++) rf[i] = 16'(i * 16'h0111);
    rf[1] = 16'd7; rf[2] = 16'd1; rf[3] = 16'd5; rf[4] = 16'd9; rf[5] = 16'd9;
    reset = 1'b1; valid1 = 1'b0; valid2 = 1'b0; instr1 = '0; instr2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_ready", 32'(ready1), 32'd1);
    chk("rst_we",    32'(we1),    32'd0);
    chk("rst_done",  32'(done1),  32'd0);
    chk("rst_psr",   32'(psr1),   32'd0);
    chk("rst_ab",    {a1, b1},    32'd0);
    chk("rst_wd",    32'(wd1),    32'd0);
    chk("rst_opc",   32'(opc1),   32'd0);
    chk("rst_addr",  32'({ra1, rb1}), 32'd0);

    run1("add",   16'h0351, 1'b1, 16'd12,    16'd7,     8'h05, 5'b00010);
    run1("addi",  16'h52FF, 1'b1, 16'h0000,  16'hFFFF,  8'h50, 5'b01011);
    run1("and",   16'h0113, 1'b1, 16'd5,     16'd5,     8'h01, 5'b01011);
    run1("cmp",   16'h04B5, 1'b0, 16'h0000,  16'd9,     8'h0B, 5'b01000);
    run1("addui", 16'h62FF, 1'b1, 16'h0100,  16'h00FF,  8'h60, 5'b01000);

    // Abort during READ
    instr1 = 16'h0351;
    valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    chk("abort_ready", 32'(ready1), 32'd1);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (we1 || done1) bad++;
      @(negedge clk);
    end
    chk("abort_no_wb", 32'(bad), 32'd0);
    chk("abort_psr",   32'(psr1), 32'd0);

    // Continuous valid on the RF_RD_LAT=2 unit
    instr2 = 16'h0351;
    valid2 = 1'b1;
    nacc = 0; last_acc = 0; dbl = 0; prev_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done2) begin
        chk("lat2_done", 32'(k), 32'(last_acc + 4));
        chk("lat2_wd",   32'(wd2), 32'd12);
        if (prev_done) dbl++;
      end
      prev_done = done2;
      if (ready2) begin
        if (nacc > 0) chk("lat2_gap", 32'(k - last_acc), 32'd5);
        last_acc = k;
        nacc++;
      end
      @(negedge clk);
    end
    valid2 = 1'b0;
    chk("lat2_accepts", 32'(nacc), 32'd8);
    chk("lat2_single_done", 32'(dbl), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
